led_row_loader: RTL and testbench

LED_ROW_LOADER -- requirements
Module: led_row_loader

---
 rtl/led_row_loader_pkg.sv | 23 ++
 rtl/led_row_loader_idle_timeout_counter.sv | 48 ++++
 rtl/led_row_loader.sv | 171 +++++++++++++++++
 tb/tb_led_row_loader.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_row_loader_pkg.sv
// -----------------------------------------------------------------------------
// led_row_loader_pkg
// Shared constants and types for the LED row loader: the frame command byte,
// the framebuffer address field widths and the parser state encoding.
// -----------------------------------------------------------------------------
package led_row_loader_pkg;

  // Command byte that opens a row frame ('L').
  localparam logic [7:0] CMD_ROW = 8'h4C;

  // wr_addr = {row, byte_index}
  localparam int ROW_W  = 5;
  localparam int IDX_W  = 8;
  localparam int ADDR_W = ROW_W + IDX_W;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ROW     = 2'd1,
    ST_DATA    = 2'd2,
    ST_DISCARD = 2'd3
  } state_e;

endpackage

// File: rtl/led_row_loader_idle_timeout_counter.sv
// -----------------------------------------------------------------------------
// idle_timeout_counter
// Counts consecutive clocks with 'clear' low, saturating at TICKS. While the
// count sits at TICKS and clear is still low, timeout_pulse is asserted, so a
// clear (a received byte) in that same cycle suppresses the timeout.
//
// Ports:
//   clk_in        in   clock, rising edge
//   reset         in   asynchronous, active-high reset
//   clear         in   restart the idle count (byte received or parser idle)
//   timeout_pulse out  idle limit reached and not cleared this cycle
// -----------------------------------------------------------------------------
module idle_timeout_counter #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TICKS = WIDTH'(4096)
) (
  input  logic clk_in,
  input  logic reset,
  input  logic clear,
  output logic timeout_pulse
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // NOTE: every signal assigned in always_comb gets a default on every path
  // first; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q != TICKS) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_pulse = (cnt_q == TICKS) && !clear;

endmodule

// File: rtl/led_row_loader.sv
// -----------------------------------------------------------------------------
// led_row_loader
// Parses row frames from a UART byte stream ('L', row index, ROW_BYTES
// payload bytes) and writes the payload into a framebuffer, one byte per
// registered write strobe. Bad row indices are consumed silently after a
// frame_error pulse; a stalled frame is abandoned after an idle timeout.
//
// Ports:
//   clk_in          in   clock, rising edge
//   reset           in   asynchronous, active-high reset
//   rx_data[7:0]    in   received byte
//   rx_data_valid   in   one-cycle strobe qualifying rx_data
//   wr_en           out  one-cycle framebuffer write strobe
//   wr_addr[12:0]   out  {row[4:0], byte_index[7:0]}
//   wr_data[7:0]    out  pixel byte
//   row_done        out  pulse coincident with the last write of a good frame
//   row_done_index  out  row of the most recent row_done (held)
//   frame_error     out  pulse on bad row index or timeout abort
//   busy            out  parser is inside a frame
// -----------------------------------------------------------------------------
module led_row_loader
  import led_row_loader_pkg::*;
#(
  parameter int          ROWS          = 32,
  parameter int          ROW_BYTES     = 256,
  parameter logic [15:0] TIMEOUT_TICKS = 16'd4096
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_data_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              row_done,
  output logic [ROW_W-1:0]  row_done_index,
  output logic              frame_error,
  output logic              busy
);

  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(ROW_BYTES - 1);
  localparam logic [8:0]       DISC_LOAD = 9'(ROW_BYTES);
  localparam logic [8:0]       ROWS_LIM  = 9'(ROWS);

  state_e             state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [8:0]         disc_q, disc_d;

  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [7:0]         wr_data_q, wr_data_d;
  logic               row_done_q, row_done_d;
  logic [ROW_W-1:0]   row_done_index_q, row_done_index_d;
  logic               frame_error_q, frame_error_d;

  logic               timeout;

  // Idle time only accrues inside a frame.
  idle_timeout_counter #(
    .WIDTH (16),
    .TICKS (TIMEOUT_TICKS)
  ) u_idle_timeout (
    .clk_in        (clk_in),
    .reset         (reset),
    .clear         (rx_data_valid || (state_q == ST_IDLE)),
    .timeout_pulse (timeout)
  );

  always_comb begin
    state_d          = state_q;
    row_d            = row_q;
    idx_d            = idx_q;
    disc_d           = disc_q;
    wr_en_d          = 1'b0;
    wr_addr_d        = wr_addr_q;
    wr_data_d        = wr_data_q;
    row_done_d       = 1'b0;
    row_done_index_d = row_done_index_q;
    frame_error_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (rx_data_valid && (rx_data == CMD_ROW)) state_d = ST_ROW;
      end

      ST_ROW: begin
        if (rx_data_valid) begin
          if ({1'b0, rx_data} < ROWS_LIM) begin
            row_d   = rx_data[ROW_W-1:0];
            idx_d   = '0;
            state_d = ST_DATA;
          end else begin
            frame_error_d = 1'b1;
            disc_d        = DISC_LOAD;
            state_d       = ST_DISCARD;
          end
        end else if (timeout) begin
          frame_error_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end

      ST_DATA: begin
        // A CMD_ROW byte here is ordinary payload; there is no resync.
        if (rx_data_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = {row_q, idx_q};
          wr_data_d = rx_data;
          if (idx_q == IDX_LAST) begin
            row_done_d       = 1'b1;
            row_done_index_d = row_q;
            state_d          = ST_IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else if (timeout) begin
          frame_error_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end

      ST_DISCARD: begin
        if (rx_data_valid) begin
          disc_d = disc_q - 9'd1;
          if (disc_q == 9'd1) state_d = ST_IDLE;
        end else if (timeout) begin
          frame_error_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      row_q            <= '0;
      idx_q            <= '0;
      disc_q           <= '0;
      wr_en_q          <= 1'b0;
      wr_addr_q        <= '0;
      wr_data_q        <= '0;
      row_done_q       <= 1'b0;
      row_done_index_q <= '0;
      frame_error_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      row_q            <= row_d;
      idx_q            <= idx_d;
      disc_q           <= disc_d;
      wr_en_q          <= wr_en_d;
      wr_addr_q        <= wr_addr_d;
      wr_data_q        <= wr_data_d;
      row_done_q       <= row_done_d;
      row_done_index_q <= row_done_index_d;
      frame_error_q    <= frame_error_d;
    end
  end

  assign wr_en          = wr_en_q;
  assign wr_addr        = wr_addr_q;
  assign wr_data        = wr_data_q;
  assign row_done       = row_done_q;
  assign row_done_index = row_done_index_q;
  assign frame_error    = frame_error_q;
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_led_row_loader.sv
// -----------------------------------------------------------------------------
// tb_led_row_loader
// Directed bench for led_row_loader. Expected writes are queued as payload
// bytes are driven and popped by a monitor on every write strobe.
// -----------------------------------------------------------------------------
module tb_led_row_loader;

  localparam int          ROWS      = 32;
  localparam int          ROW_BYTES = 256;
  localparam int          TICKS     = 4096;

  logic        clk_in = 1'b0;
  logic        reset  = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_data_valid = 1'b0;
  logic        wr_en;
  logic [12:0] wr_addr;
  logic [7:0]  wr_data;
  logic        row_done;
  logic [4:0]  row_done_index;
  logic        frame_error;
  logic        busy;

  led_row_loader #(
    .ROWS          (ROWS),
    .ROW_BYTES     (ROW_BYTES),
    .TIMEOUT_TICKS (16'(TICKS))
  ) dut (
    .clk_in         (clk_in),
    .reset          (reset),
    .rx_data        (rx_data),
    .rx_data_valid  (rx_data_valid),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .row_done       (row_done),
    .row_done_index (row_done_index),
    .frame_error    (frame_error),
    .busy           (busy)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [12:0] addr;
    logic [7:0]  data;
    logic        last;
    logic [4:0]  row;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests    = 0;
  int   fails    = 0;
  int   err_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: sample outputs mid-cycle, away from the rising edge.
  always @(negedge clk_in) begin
    if (wr_en) begin
      check("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
        check("wr_data", 32'(wr_data), 32'(mon_e.data));
        check("row_done_on_last", 32'(row_done), 32'(mon_e.last));
        if (mon_e.last) check("row_done_index", 32'(row_done_index), 32'(mon_e.row));
      end
    end
    if (row_done) check("row_done_with_wr", 32'(wr_en), 32'd1);
    if (frame_error) begin
      err_seen++;
      check("err_no_overlap", 32'(wr_en | row_done), 32'd0);
    end
  end

  // Inputs change 1 ns after a rising edge; each call ends at the same phase.
  task automatic send_byte(input logic [7:0] b);
    rx_data       = b;
    rx_data_valid = 1'b1;
    @(posedge clk_in); #1;
    rx_data_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_in); #1;
    end
  endtask

  task automatic send_header(input logic [7:0] row);
    send_byte(8'h4C);
    send_byte(row);
  endtask

  // Payload byte i is i, except byte 0 becomes 'L' when first_l is set.
  task automatic send_payload(input logic [7:0] row, input int from, input int upto,
                              input logic first_l);
    logic [7:0] d;
    exp_t       e;
    for (int i = from; i < upto; i++) begin
      d = (i == 0 && first_l) ? 8'h4C : 8'(i);
      if (32'(row) < ROWS) begin
        e.addr = {row[4:0], 8'(i)};
        e.data = d;
        e.last = (i == ROW_BYTES - 1);
        e.row  = row[4:0];
        exp_q.push_back(e);
      end
      send_byte(d);
    end
  endtask

  task automatic send_frame(input logic [7:0] row, input logic first_l);
    send_header(row);
    send_payload(row, 0, ROW_BYTES, first_l);
  endtask

  initial begin
    int err_base;

    // Reset state
    #2;
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    check("rst_row_done", 32'(row_done), 0);
    check("rst_row_done_index", 32'(row_done_index), 0);
    check("rst_frame_error", 32'(frame_error), 0);
    check("rst_busy", 32'(busy), 0);
    idle(3);
    reset = 1'b0;
    idle(1);

    // Full frame for row 4
    send_frame(8'h04, 1'b0);
    idle(2);
    check("f4_all_written", 32'(exp_q.size()), 0);
    check("f4_row_done_index", 32'(row_done_index), 32'd4);
    check("f4_busy_low", 32'(busy), 0);
    check("f4_no_error", 32'(err_seen), 0);

    // Out-of-range row is discarded, next frame is normal
    send_frame(8'h20, 1'b0);
    idle(2);
    check("bad_row_error_once", 32'(err_seen), 32'd1);
    check("bad_row_busy_low", 32'(busy), 0);
    check("bad_row_index_held", 32'(row_done_index), 32'd4);
    send_frame(8'h01, 1'b0);
    idle(2);
    check("f1_all_written", 32'(exp_q.size()), 0);
    check("f1_row_done_index", 32'(row_done_index), 32'd1);
    check("f1_error_count", 32'(err_seen), 32'd1);

    // Noise in IDLE, then a frame whose first payload byte is 'L'
    send_byte(8'h00);
    send_byte(8'h55);
    idle(1);
    check("noise_busy_low", 32'(busy), 0);
    send_frame(8'h09, 1'b1);
    idle(2);
    check("f9_all_written", 32'(exp_q.size()), 0);
    check("f9_row_done_index", 32'(row_done_index), 32'd9);
    check("f9_error_count", 32'(err_seen), 32'd1);

    // Timeout after 10 payload bytes
    send_header(8'h02);
    send_payload(8'h02, 0, 10, 1'b0);
    idle(TICKS);
    check("to_writes_done", 32'(exp_q.size()), 0);
    check("to_busy_at_limit", 32'(busy), 32'd1);
    check("to_no_error_yet", 32'(err_seen), 32'd1);
    idle(1);
    check("to_frame_error", 32'(frame_error), 32'd1);
    check("to_busy_fell", 32'(busy), 0);
    idle(2);
    check("to_error_count", 32'(err_seen), 32'd2);
    send_frame(8'h05, 1'b0);
    idle(2);
    check("f5_all_written", 32'(exp_q.size()), 0);
    check("f5_row_done_index", 32'(row_done_index), 32'd5);

    // Byte lands on the timeout cycle: the byte wins
    send_header(8'h06);
    send_payload(8'h06, 0, 10, 1'b0);
    idle(TICKS);
    send_payload(8'h06, 10, ROW_BYTES, 1'b0);
    idle(2);
    check("edge_no_error", 32'(err_seen), 32'd2);
    check("f6_all_written", 32'(exp_q.size()), 0);
    check("f6_row_done_index", 32'(row_done_index), 32'd6);

    // Reset mid-frame after 100 payload bytes
    err_base = err_seen;
    send_header(8'h07);
    send_payload(8'h07, 0, 100, 1'b0);
    idle(1);
    check("f7_partial_written", 32'(exp_q.size()), 0);
    check("f7_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_wr_en", 32'(wr_en), 0);
    check("mid_rst_wr_addr", 32'(wr_addr), 0);
    check("mid_rst_wr_data", 32'(wr_data), 0);
    check("mid_rst_row_done_index", 32'(row_done_index), 0);
    check("mid_rst_frame_error", 32'(frame_error), 0);
    check("mid_rst_busy", 32'(busy), 0);
    idle(3);
    reset = 1'b0;
    idle(2);
    check("mid_rst_no_error", 32'(err_seen), 32'(err_base));
    send_frame(8'h03, 1'b0);
    idle(2);
    check("f3_all_written", 32'(exp_q.size()), 0);
    check("f3_row_done_index", 32'(row_done_index), 32'd3);
    check("f3_no_error", 32'(err_seen), 32'(err_base));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
